serial_xs3_bcd_codec: RTL and testbench



---
 rtl/serial_xs3_bcd_codec.sv | 122 ++++++++++++
 tb/tb_serial_xs3_bcd_codec.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_xs3_bcd_codec.sv
// Bit-serial LSB-first Excess-3 <-> BCD codec with word framing,
// valid stalling and per-digit code-error flags.
module serial_xs3_bcd_codec #(
    parameter int DIGITS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic mode_i,
    input  logic valid_i,
    input  logic x_i,
    output logic z_o,
    output logic zvalid_o,
    output logic digit_err_o,
    output logic word_done_o,
    output logic word_err_o
);

    localparam int              DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0]   DLAST = DW'(DIGITS - 1);
    localparam logic [3:0]      K     = 4'b0011;

    logic [1:0]    p_q, p_d;
    logic          c_q, c_d;
    logic [DW-1:0] d_q, d_d;
    logic          m_q, m_d;
    logic [2:0]    h_q, h_d;
    logic          e_q, e_d;
    logic          derr_q, derr_d;
    logic          wdone_q, wdone_d;
    logic          werr_q, werr_d;

    logic       word_start;
    logic       em;
    logic       k;
    logic       zr;
    logic       borrow;
    logic       carry;
    logic       cn;
    logic       hin;
    logic [3:0] n;
    logic       dig_err;
    logic       last_bit;
    logic       last_dig;

    // Mode is only looked at on the very first bit of a word.
    always_comb begin
        word_start = (p_q == 2'd0) && (d_q == '0);
        em         = word_start ? mode_i : m_q;
        k          = K[p_q];
        zr         = x_i ^ k ^ c_q;
        borrow     = (~x_i & (k | c_q)) | (k & c_q);
        carry      = (x_i & k) | (x_i & c_q) | (k & c_q);
        cn         = em ? carry : borrow;
        hin        = em ? x_i : zr;
        n          = {hin, h_q};
        dig_err    = (n > 4'd9) | (~em & cn);
        last_bit   = (p_q == 2'd3);
        last_dig   = (d_q == DLAST);
    end

    assign z_o      = valid_i & rst_ni & zr;
    assign zvalid_o = valid_i;

    always_comb begin
        p_d     = p_q;
        c_d     = c_q;
        d_d     = d_q;
        m_d     = m_q;
        h_d     = h_q;
        e_d     = e_q;
        derr_d  = 1'b0;
        wdone_d = 1'b0;
        werr_d  = 1'b0;
        if (valid_i) begin
            p_d = p_q + 2'd1;
            c_d = last_bit ? 1'b0 : cn;
            m_d = em;
            h_d = {hin, h_q[2:1]};
            if (last_bit) begin
                derr_d = dig_err;
                if (last_dig) begin
                    d_d     = '0;
                    e_d     = 1'b0;
                    wdone_d = 1'b1;
                    werr_d  = e_q | dig_err;
                end else begin
                    d_d = d_q + DW'(1);
                    e_d = e_q | dig_err;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q     <= 2'd0;
            c_q     <= 1'b0;
            d_q     <= '0;
            m_q     <= 1'b0;
            h_q     <= 3'd0;
            e_q     <= 1'b0;
            derr_q  <= 1'b0;
            wdone_q <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            c_q     <= c_d;
            d_q     <= d_d;
            m_q     <= m_d;
            h_q     <= h_d;
            e_q     <= e_d;
            derr_q  <= derr_d;
            wdone_q <= wdone_d;
            werr_q  <= werr_d;
        end
    end

    assign digit_err_o = derr_q;
    assign word_done_o = wdone_q;
    assign word_err_o  = werr_q;

endmodule

// File: tb/tb_serial_xs3_bcd_codec.sv
// Bench for serial_xs3_bcd_codec: three widths (1, 2, 4 digits) share
// one stimulus stream and are checked against a digit-level +/-3 model.
module tb_serial_xs3_bcd_codec;

    logic clk;
    logic rst_n;
    logic mode;
    logic valid;
    logic x;

    logic [2:0] z_w, zv_w, derr_w, wd_w, we_w;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_xs3_bcd_codec #(.DIGITS(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .valid_i(valid), .x_i(x),
        .z_o(z_w[0]), .zvalid_o(zv_w[0]), .digit_err_o(derr_w[0]),
        .word_done_o(wd_w[0]), .word_err_o(we_w[0])
    );
    serial_xs3_bcd_codec #(.DIGITS(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .valid_i(valid), .x_i(x),
        .z_o(z_w[1]), .zvalid_o(zv_w[1]), .digit_err_o(derr_w[1]),
        .word_done_o(wd_w[1]), .word_err_o(we_w[1])
    );
    serial_xs3_bcd_codec #(.DIGITS(4)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .valid_i(valid), .x_i(x),
        .z_o(z_w[2]), .zvalid_o(zv_w[2]), .digit_err_o(derr_w[2]),
        .word_done_o(wd_w[2]), .word_err_o(we_w[2])
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    // Digit-level model: collect the digit value, apply +/-3 mod 16.
    int         nd   [3] = '{1, 2, 4};
    logic [3:0] part [3];
    int         pos  [3];
    int         dig  [3];
    logic       wm   [3];
    logic       wer  [3];
    logic       ede  [3];
    logic       ewd  [3];
    logic       ewe  [3];

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            logic [3:0] r;
            logic       ez;
            logic       err;
            chk($sformatf("u%0d_zvalid", u), zv_w[u], valid);
            if (!rst_n) begin
                chk($sformatf("u%0d_rst_z", u), z_w[u], 1'b0);
                chk($sformatf("u%0d_rst_derr", u), derr_w[u], 1'b0);
                chk($sformatf("u%0d_rst_wdone", u), wd_w[u], 1'b0);
                chk($sformatf("u%0d_rst_werr", u), we_w[u], 1'b0);
                part[u] = 4'd0; pos[u] = 0; dig[u] = 0;
                wm[u] = 1'b0; wer[u] = 1'b0;
                ede[u] = 1'b0; ewd[u] = 1'b0; ewe[u] = 1'b0;
            end else begin
                chk($sformatf("u%0d_derr", u), derr_w[u], ede[u]);
                chk($sformatf("u%0d_wdone", u), wd_w[u], ewd[u]);
                chk($sformatf("u%0d_werr", u), we_w[u], ewe[u]);
                ede[u] = 1'b0; ewd[u] = 1'b0; ewe[u] = 1'b0;
                if (valid) begin
                    if (pos[u] == 0 && dig[u] == 0) wm[u] = mode;
                    part[u][pos[u]] = x;
                    r  = wm[u] ? part[u] + 4'd3 : part[u] - 4'd3;
                    ez = r[pos[u]];
                    chk($sformatf("u%0d_z", u), z_w[u], ez);
                    pos[u]++;
                    if (pos[u] == 4) begin
                        err = wm[u] ? (part[u] > 4'd9)
                                    : (part[u] < 4'd3 || part[u] > 4'd12);
                        ede[u] = err;
                        if (dig[u] == nd[u] - 1) begin
                            ewd[u] = 1'b1;
                            ewe[u] = wer[u] | err;
                            wer[u] = 1'b0;
                            dig[u] = 0;
                        end else begin
                            wer[u] = wer[u] | err;
                            dig[u]++;
                        end
                        pos[u]  = 0;
                        part[u] = 4'd0;
                    end
                end else begin
                    chk($sformatf("u%0d_stall_z", u), z_w[u], 1'b0);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic xb, input logic md);
        @(posedge clk);
        #2;
        valid = v;
        x     = xb;
        mode  = md;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send_digit(input logic md, input logic [3:0] bits,
                              input logic [3:0] ez, input logic eerr);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[i], md);
            #1;
            chk($sformatf("lit_z%0d", i), z_w[0], ez[i]);
        end
        drive(1'b0, 1'b0, md);
        #1;
        chk("lit_derr", derr_w[0], eerr);
        chk("lit_wdone", wd_w[0], 1'b1);
        chk("lit_werr", we_w[0], eerr);
    endtask

    logic [3:0] w2_bits [2] = '{4'b0011, 4'b1100};
    logic [3:0] w2_z    [2] = '{4'b0000, 4'b1001};

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        x     = 1'b0;
        mode  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        send_digit(1'b0, 4'b0111, 4'b0100, 1'b0);
        send_digit(1'b1, 4'b1001, 4'b1100, 1'b0);
        send_digit(1'b0, 4'b0001, 4'b1110, 1'b1);
        send_digit(1'b0, 4'b1111, 4'b1100, 1'b1);
        send_digit(1'b1, 4'b1010, 4'b1101, 1'b1);

        // Two-digit XS3 word with a stall and a mid-word mode flip.
        do_reset();
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, w2_bits[dd][i], (dd == 1) ? 1'b1 : 1'b0);
                #1;
                chk($sformatf("w2_z%0d_%0d", dd, i), z_w[1], w2_z[dd][i]);
                if (dd == 1 && i == 1) begin
                    for (int s = 0; s < 3; s++) begin
                        drive(1'b0, 1'b1, 1'b1);
                        #1;
                        chk("w2_stall_z", z_w[1], 1'b0);
                        chk("w2_stall_wdone", wd_w[1], 1'b0);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        #1;
        chk("w2_wdone", wd_w[1], 1'b1);
        chk("w2_werr", we_w[1], 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        chk("w2_wdone_once", wd_w[1], 1'b0);

        // Random streams, one phase per mode, with random stalls.
        do_reset();
        for (int md = 0; md < 2; md++) begin
            for (int n = 0; n < 2000 * 4; n++) begin
                while ($urandom_range(3) == 0)
                    drive(1'b0, 1'($urandom_range(1)), md[0]);
                drive(1'b1, 1'($urandom_range(1)), md[0]);
            end
        end

        // Reset after bit 2 of a digit, then a clean digit from p = 0.
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b1;
        x     = 1'b1;
        #1;
        chk("rst_mid_z", z_w[0], 1'b0);
        chk("rst_mid_derr", derr_w[0], 1'b0);
        chk("rst_mid_wdone", wd_w[0], 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        valid = 1'b0;
        send_digit(1'b1, 4'b0101, 4'b1000, 1'b0);

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
